// File: rtl/fifo_byte_packer.sv
// Drains a show-ahead byte FIFO and packs bytes little-endian into WORD_BYTES-byte words,
// handed downstream over valid/ready with byte enables; a flush pulse closes a partial word.
module fifo_byte_packer #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned IDX_W     = $clog2(WORD_BYTES) + 1
) (
    input  logic                    clockCore,
    input  logic                    resetCore,
    input  logic                    fifoEmpty,
    input  logic [7:0]              fifoData,
    output logic                    fifoPop,
    input  logic                    flush,
    output logic [8*WORD_BYTES-1:0] wordData,
    output logic [WORD_BYTES-1:0]   wordByteEn,
    output logic                    wordLast,
    output logic                    wordValid,
    input  logic                    wordReady,
    output logic [IDX_W-1:0]        byteIdx,
    output logic [CNT_W-1:0]        bytesPacked
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORD_BYTES - 1);

    typedef enum logic [0:0] {StCollect, StFlushWait} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [8*WORD_BYTES-1:0] acc_q, acc_d;
    logic [8*WORD_BYTES-1:0] word_data_q, word_data_d;
    logic [WORD_BYTES-1:0]   word_be_q, word_be_d;
    logic                    word_last_q, word_last_d;
    logic                    word_valid_q, word_valid_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    out_free;
    logic                    pop;
    logic                    load;
    logic [8*WORD_BYTES-1:0] load_data;
    logic [WORD_BYTES-1:0]   load_be;
    logic                    load_last;
    logic [8*WORD_BYTES-1:0] acc_pop;
    logic [IDX_W-1:0]        idx_pop;

    // Contiguous enable mask covering the lowest n bytes.
    function automatic logic [WORD_BYTES-1:0] be_mask(input logic [IDX_W-1:0] n);
        logic [WORD_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            m[i] = (IDX_W'(i) < n);
        end
        return m;
    endfunction

    always_comb begin
        out_free     = !word_valid_q || wordReady;
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        word_data_d  = word_data_q;
        word_be_d    = word_be_q;
        word_last_d  = word_last_q;
        word_valid_d = word_valid_q && !wordReady;
        pop          = 1'b0;
        load         = 1'b0;
        load_data    = '0;
        load_be      = '0;
        load_last    = 1'b0;
        acc_pop      = acc_q;
        idx_pop      = idx_q;

        unique case (state_q)
            StCollect: begin
                // The completing byte is held back in the FIFO until the output can load.
                pop = !resetCore && !fifoEmpty && ((idx_q < LastIdx) || out_free);
                if (pop) begin
                    for (int i = 0; i < WORD_BYTES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            acc_pop[8*i +: 8] = fifoData;
                        end
                    end
                    idx_pop = idx_q + IDX_W'(1);
                end

                if (pop && (idx_q == LastIdx)) begin
                    load      = 1'b1;
                    load_data = acc_pop;
                    load_be   = '1;
                    load_last = flush;
                end else if (flush && (idx_pop != '0)) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_data = acc_pop;
                        load_be   = be_mask(idx_pop);
                        load_last = 1'b1;
                    end else begin
                        state_d = StFlushWait;
                        acc_d   = acc_pop;
                        idx_d   = idx_pop;
                    end
                end else begin
                    acc_d = acc_pop;
                    idx_d = idx_pop;
                end
            end
            StFlushWait: begin
                // Further flush pulses merge with the one already pending.
                if (out_free) begin
                    load      = 1'b1;
                    load_data = acc_q;
                    load_be   = be_mask(idx_q);
                    load_last = 1'b1;
                    state_d   = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase

        if (load) begin
            word_valid_d = 1'b1;
            word_data_d  = load_data;
            word_be_d    = load_be;
            word_last_d  = load_last;
            acc_d        = '0;
            idx_d        = '0;
        end

        cnt_d = cnt_q + CNT_W'(pop);
    end

    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            state_q      <= StCollect;
            idx_q        <= '0;
            acc_q        <= '0;
            word_data_q  <= '0;
            word_be_q    <= '0;
            word_last_q  <= 1'b0;
            word_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            word_data_q  <= word_data_d;
            word_be_q    <= word_be_d;
            word_last_q  <= word_last_d;
            word_valid_q <= word_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign fifoPop     = pop;
    assign wordData    = word_data_q;
    assign wordByteEn  = word_be_q;
    assign wordLast    = word_last_q;
    assign wordValid   = word_valid_q;
    assign byteIdx     = idx_q;
    assign bytesPacked = cnt_q;

endmodule
